// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: preamble/SFD hunt, LSB-first byte assembly and end-of-frame status.
// Define RX_CRC_CHECK_EN to build the CRC-32 FCS check into the frame error flag.
module rmii_rx_deframer #(
  parameter int MAX_LEN = 1522
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic [1:0]  rx_dibit,
  input  logic        rx_dv,
  input  logic        rx_err_in,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [10:0] out_len
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

  state_t      state_q, state_d;
  logic [1:0]  dibit_cnt;
  logic [5:0]  part_byte;
  logic [10:0] byte_cnt;
  logic        seen_01;
  logic        err_lat;
  logic        drop_eof;
  logic        seen_eff;
  logic        frame_start;
  logic        byte_done;
  logic        over;
  logic        emit;
  logic        eof_fire;
  logic        eof_err;
  logic        crc_bad;
  logic [7:0]  full_byte;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, PREAMBLE: begin
        if (!rx_dv)                 state_d = IDLE;
        else if (rx_dibit == 2'b10) state_d = DROP;
        else if (rx_dibit == 2'b11) state_d = seen_eff ? DATA : DROP;
        else                        state_d = PREAMBLE;
      end
      DATA: begin
        if (!rx_dv)    state_d = IDLE;
        else if (over) state_d = DROP;
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The first dibit seen in IDLE never has a prior 01 behind it.
  always_comb begin
    seen_eff    = (state_q == PREAMBLE) && seen_01;
    frame_start = (state_q == PREAMBLE) && rx_dv && (rx_dibit == 2'b11) && seen_01;
    byte_done   = (state_q == DATA) && rx_dv && (dibit_cnt == 2'd3);
    over        = byte_done && (byte_cnt >= MAX_LEN_W);
    emit        = byte_done && !over;
    full_byte   = {rx_dibit, part_byte};
    eof_fire    = !rx_dv && ((state_q == DATA) || ((state_q == DROP) && drop_eof));
    eof_err     = (state_q == DROP) || err_lat || (dibit_cnt != 2'd0) ||
                  (byte_cnt == 11'd0) || crc_bad;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      seen_01   <= 1'b0;
      dibit_cnt <= 2'd0;
      part_byte <= 6'd0;
      byte_cnt  <= 11'd0;
      err_lat   <= 1'b0;
      drop_eof  <= 1'b0;
    end else begin
      if (state_q == IDLE || state_q == PREAMBLE) begin
        drop_eof <= 1'b0;
        if (rx_dv) seen_01 <= (rx_dibit == 2'b01) || seen_eff;
      end
      if (frame_start) begin
        dibit_cnt <= 2'd0;
        byte_cnt  <= 11'd0;
        err_lat   <= 1'b0;
      end else if (state_q == DATA && rx_dv) begin
        dibit_cnt <= dibit_cnt + 2'd1;
        case (dibit_cnt)
          2'd0:    part_byte[1:0] <= rx_dibit;
          2'd1:    part_byte[3:2] <= rx_dibit;
          2'd2:    part_byte[5:4] <= rx_dibit;
          default: part_byte      <= part_byte;
        endcase
        if (rx_err_in || over) err_lat <= 1'b1;
        if (over)              drop_eof <= 1'b1;
        if (emit)              byte_cnt <= sat_inc(byte_cnt);
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      out_len   <= 11'd0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit && (byte_cnt == 11'd0);
      out_eof   <= eof_fire;
      if (emit) out_data <= full_byte;
      if (eof_fire) begin
        out_len <= byte_cnt;
        out_err <= eof_err;
      end
    end
  end

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc_q;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Running over data plus FCS leaves the fixed residue when the FCS is intact.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n)         crc_q <= 32'hFFFFFFFF;
    else if (frame_start) crc_q <= 32'hFFFFFFFF;
    else if (emit)        crc_q <= crc32_byte(crc_q, full_byte);
  end

  assign crc_bad = (crc_q != 32'hDEBB20E3);
`else
  assign crc_bad = 1'b0;
`endif

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Bench for rmii_rx_deframer: directed frame sequence with random payloads, checked against a
// frame-level model of emitted bytes and end-of-frame records.
module tb_rmii_rx_deframer;
  localparam int MAX_LEN = 64;
`ifdef RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic [1:0]  rx_dibit;
  logic        rx_dv;
  logic        rx_err_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [10:0] out_len;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [7:0]  frm[$];
  logic [8:0]  exp_b[$];
  logic [8:0]  obs_b[$];
  logic [12:0] exp_e[$];
  logic [12:0] obs_e[$];

  always #10 sysclk = ~sysclk;

  rmii_rx_deframer #(.MAX_LEN(MAX_LEN)) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .rx_dibit (rx_dibit),
    .rx_dv    (rx_dv),
    .rx_err_in(rx_err_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .out_err  (out_err),
    .out_len  (out_len)
  );

  always @(negedge sysclk) begin
    if (reset_n) begin
      if (out_valid) obs_b.push_back({out_sof, out_data});
      if (out_eof)   obs_e.push_back({out_valid, out_err, out_len});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic dv, input logic [1:0] d, input logic e);
    rx_dv = dv;
    rx_dibit = d;
    rx_err_in = e;
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'($urandom), 1'($urandom));
  endtask

  // Ethernet FCS, computed MSB-first on the wire bit order, then reflected and complemented.
  function automatic logic [31:0] eth_fcs(input int n);
    logic [31:0] c;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ frm[i][b];
        c = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    for (int j = 0; j < 32; j++) r[j] = c[31-j];
    return ~r;
  endfunction

  function automatic bit fcs_ok();
    int n;
    n = frm.size();
    if (n < 4) return 1'b0;
    return eth_fcs(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
  endfunction

  task automatic build_frame(input int payload);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < payload; i++) frm.push_back(8'($urandom));
    f = eth_fcs(payload);
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
    frm.push_back(f[23:16]);
    frm.push_back(f[31:24]);
  endtask

  task automatic model_frame(input int extra, input bit phy_err);
    int n;
    int emitted;
    bit err;
    n = frm.size();
    emitted = (n > MAX_LEN) ? MAX_LEN : n;
    for (int i = 0; i < emitted; i++) exp_b.push_back({(i == 0), frm[i]});
    err = phy_err || (extra % 4 != 0) || (n > MAX_LEN) || (n == 0) || (CRC_EN && !fcs_ok());
    exp_e.push_back({1'b0, err, 11'(emitted)});
  endtask

  task automatic send_pre(input bit short_pre);
    logic [7:0] b;
    if (short_pre) begin
      cyc(1'b1, 2'b01, 1'b0);
      cyc(1'b1, 2'b11, 1'b0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        b = (i == 7) ? 8'hD5 : 8'h55;
        for (int k = 0; k < 4; k++) cyc(1'b1, b[2*k +: 2], 1'b0);
      end
    end
  endtask

  task automatic send_frame(input int extra, input int err_at, input bit short_pre);
    send_pre(short_pre);
    for (int i = 0; i < frm.size(); i++)
      for (int k = 0; k < 4; k++) cyc(1'b1, frm[i][2*k +: 2], (4*i + k) == err_at);
    for (int k = 0; k < extra; k++) cyc(1'b1, 2'($urandom), 1'b0);
    model_frame(extra, err_at >= 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, " byte count"}, 32'(obs_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++)
      chk($sformatf("%s sof/byte %0d", tag, i), 32'(obs_b[i]), 32'(exp_b[i]));
    chk({tag, " eof count"}, 32'(obs_e.size()), 32'(exp_e.size()));
    for (int i = 0; i < exp_e.size() && i < obs_e.size(); i++)
      chk($sformatf("%s eof valid/err/len %0d", tag, i), 32'(obs_e[i]), 32'(exp_e[i]));
    obs_b.delete();
    exp_b.delete();
    obs_e.delete();
    exp_e.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " out_data"},  32'(out_data),  32'h0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, " out_sof"},   32'(out_sof),   32'h0);
    chk({tag, " out_eof"},   32'(out_eof),   32'h0);
    chk({tag, " out_err"},   32'(out_err),   32'h0);
    chk({tag, " out_len"},   32'(out_len),   32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    rx_dv = 1'b0;
    rx_dibit = 2'b00;
    rx_err_in = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    idle(4);

    build_frame(60);
    send_frame(0, -1, 1'b0);
    idle(6);
    check_all("clean");

    frm[63] = ~frm[63];
    send_frame(0, -1, 1'b0);
    idle(6);
    check_all("corrupt_fcs");

    for (int t = 0; t < 3; t++) begin
      build_frame(int'($urandom_range(1, 56)));
      send_frame(0, -1, 1'b0);
      idle(5);
      check_all("rand_frame");
    end

    frm.delete();
    for (int i = 0; i < 10; i++) frm.push_back(8'($urandom));
    send_frame(1, -1, 1'b0);
    idle(6);
    check_all("misaligned");

    frm.delete();
    send_frame(0, -1, 1'b0);
    idle(6);
    check_all("empty");

    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 97; i++) cyc(1'b1, 2'($urandom), 1'($urandom));
    idle(6);
    check_all("bad_preamble");

    build_frame(66);
    send_frame(0, -1, 1'b0);
    idle(6);
    check_all("oversize");

    build_frame(20);
    send_frame(0, 30, 1'b0);
    idle(6);
    check_all("phy_err");

    build_frame(30);
    send_frame(0, -1, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
    build_frame(12);
    send_frame(0, -1, 1'b1);
    idle(6);
    check_all("back_to_back");

    build_frame(40);
    send_pre(1'b0);
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 4; k++) cyc(1'b1, frm[i][2*k +: 2], 1'b0);
    cyc(1'b1, frm[5][1:0], 1'b0);
    cyc(1'b1, frm[5][3:2], 1'b0);
    for (int i = 0; i < 5; i++) exp_b.push_back({(i == 0), frm[i]});
    reset_n = 1'b0;
    #2;
    chk_reset_outputs("abort_reset");
    @(posedge sysclk);
    #1;
    rx_dv = 1'b0;
    @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    idle(4);
    check_all("reset_abort");

    build_frame(60);
    send_frame(0, -1, 1'b0);
    idle(6);
    check_all("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rmii_rx_deframer.md
RMII_RX_DEFRAMER -- requirements
Module: rmii_rx_deframer

Interface
REQ-001 The block SHALL have a parameter MAX_LEN, default 1522, giving the maximum accepted frame length in bytes after the SFD, FCS included.
REQ-002 The block SHALL have the port sysclk, input, 1 bit: the single clock. It is 50 MHz, and every cycle with rx_dv high carries one new dibit.
REQ-003 The block SHALL have the port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have the port rx_dibit, input, 2 bits: RMII receive dibit, already synchronised to sysclk, LSB-first on the line.
REQ-005 The block SHALL have the port rx_dv, input, 1 bit: receive data valid, synchronised.
REQ-006 The block SHALL have the port rx_err_in, input, 1 bit: PHY receive error, synchronised.
REQ-007 The block SHALL have the port out_data, output, 8 bits: assembled byte.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: out_data is valid this cycle.
REQ-009 The block SHALL have the port out_sof, output, 1 bit: asserted with out_valid on the first byte after the SFD.
REQ-010 The block SHALL have the port out_eof, output, 1 bit: single-cycle end-of-frame pulse, always with out_valid low.
REQ-011 The block SHALL have the port out_err, output, 1 bit: frame error, qualified by out_eof.
REQ-012 The block SHALL have the port out_len, output, 11 bits: byte count of the frame, qualified by out_eof.

Function
REQ-013 The block SHALL implement the states IDLE, PREAMBLE, DATA and DROP.
REQ-014 IDLE SHALL move to PREAMBLE on the first cycle rx_dv=1, and that dibit SHALL be evaluated as a preamble dibit.
REQ-015 PREAMBLE SHALL behave as follows:
- dibits 00 and 01 are accepted;
- dibit 11 moves the block to DATA only if at least one 01 has been seen, otherwise to DROP;
- dibit 10 moves the block to DROP;
- rx_dv=0 returns the block to IDLE with no output.
REQ-016 DATA SHALL assemble bytes LSB-first: dibit k of a byte (k=0..3) SHALL land in bits [2k+1:2k].
REQ-017 out_valid SHALL be asserted for one cycle, one cycle after the cycle carrying the 4th dibit (latency 1).
REQ-018 out_sof SHALL accompany only the first byte of each frame.
REQ-019 A 2-bit dibit counter SHALL wrap from 3 to 0 at each byte boundary.
REQ-020 The frame byte counter SHALL increment for each emitted byte and saturate at 2047.
REQ-021 In DATA, the first cycle with rx_dv=0 SHALL cause out_eof one cycle later, and the block SHALL return to IDLE.
REQ-022 out_err SHALL be 1 at out_eof if any of the following holds:
- the dibit counter is not 0 at the fall of rx_dv (misaligned frame);
- rx_err_in was 1 on any cycle in DATA;
- the length exceeded MAX_LEN;
- zero bytes were emitted;
- the CRC check fails (REQ-030).
REQ-023 When byte MAX_LEN+1 would complete, that byte SHALL NOT be emitted and the block SHALL enter DROP with the error latched.
REQ-024 DROP SHALL emit nothing until rx_dv=0.
REQ-025 When DROP is entered from DATA, leaving DROP SHALL produce out_eof with out_err=1; when DROP is entered from PREAMBLE, leaving it SHALL produce no out_eof.
REQ-026 out_len SHALL equal the number of bytes emitted with out_valid.
REQ-027 If rx_dv rises on the cycle immediately after out_eof, that dibit SHALL be taken as the start of a new preamble and SHALL NOT be lost.
REQ-028 rx_dibit and rx_err_in SHALL be ignored while rx_dv=0.

Reset
REQ-029 While reset_n=0 the block SHALL be in IDLE, with out_data=0x00, out_valid, out_sof, out_eof and out_err all 0, out_len=0, the internal counters at 0, and the CRC register at 0xFFFFFFFF. Assertion mid-frame SHALL abort the frame with no out_eof, and after release the next frame SHALL be received normally.

Configuration
REQ-030 With macro RX_CRC_CHECK_EN defined, the block SHALL run a reflected CRC-32 (polynomial 0x04C11DB7, init 0xFFFFFFFF, no final XOR) over every emitted byte, FCS included, and SHALL flag out_err at out_eof when the register is not 0xDEBB20E3.
REQ-031 Without RX_CRC_CHECK_EN, no CRC logic SHALL be built and the CRC term SHALL never contribute to out_err.

Verification
REQ-032 Scenario "clean frame": 7×0x55 preamble, SFD 0xD5, then 64 bytes (60 payload + valid FCS) -> 64 out_valid pulses, out_sof on byte 0, out_eof with out_len=64 and out_err=0 in both builds.
REQ-033 Scenario "corrupt FCS": same frame with the last FCS byte inverted -> out_err=1 with the macro defined; out_err=0 without it; out_len=64.
REQ-034 Scenario "misaligned end": valid preamble/SFD, 10 bytes plus 1 extra dibit, then rx_dv=0 -> 10 bytes emitted, out_eof with out_len=10 and out_err=1.
REQ-035 Scenario "bad preamble": rx_dv high with dibits 01,01,10,... for 100 cycles -> no out_valid and no out_eof.
REQ-036 Scenario "oversize": MAX_LEN=64, 70-byte frame -> exactly 64 bytes emitted, then out_eof with out_len=64 and out_err=1.
REQ-037 Scenario "PHY error and reset abort": rx_err_in=1 for one cycle mid-frame -> out_err=1 at out_eof. Separately, reset_n pulsed low during byte 5 -> no out_eof, and the following clean frame is received correctly.
